shift_add_multiplier: RTL and testbench



---
 rtl/shift_add_multiplier_pkg.sv | 15 +
 rtl/shift_add_multiplier_adder_core.sv | 28 ++
 rtl/shift_add_multiplier.sv | 122 ++++++++++++
 tb/tb_shift_add_multiplier.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   - FSM state encoding (2'd3 is unreachable and decodes to IDLE)
//   - default operand width
package shift_add_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DONE   = 2'd2,
    ST_UNUSED = 2'd3
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_adder_core.sv
// adder_core: WIDTH-bit ripple-carry adder.
// Ports:
//   a, b   : WIDTH-bit addends
//   c_in   : carry in
//   sum    : WIDTH-bit sum
//   c_out  : carry out of the MSB
module adder_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  logic [WIDTH:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = carry[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned WIDTH x WIDTH -> 2*WIDTH multiplier,
// one shift-and-add step per clock through a ripple-carry adder_core.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous reset, active-high
//   in_valid   : a, b valid
//   in_ready   : operands accepted (high only in IDLE)
//   a, b       : multiplicand, multiplier (sampled at the accept edge only)
//   out_valid  : product valid (DONE state)
//   out_ready  : consumer accepts product
//   product    : a*b, held stable while out_valid=1
//   done_count : (only with SHIFT_ADD_MULT_DONE_CNT_EN defined) 16-bit wrapping
//                count of completed output handshakes
// Optional feature macro: SHIFT_ADD_MULT_DONE_CNT_EN.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
`ifdef SHIFT_ADD_MULT_DONE_CNT_EN
  ,
  output logic [15:0]        done_count
`endif
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [2*WIDTH-1:0] shifted;

  // Partial product: add the multiplicand only when the current multiplier bit is set.
  assign addend = lo[0] ? mcand : '0;

  adder_core #(.WIDTH(WIDTH)) u_adder (
    .a     (hi),
    .b     (addend),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (carry)
  );

  // {carry, sum, lo} >> 1: the carry is kept as the new MSB, so the product
  // can never overflow 2*WIDTH bits.
  assign shifted = {carry, sum, lo[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mcand     <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      product   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= a;
            lo       <= b;
            hi       <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          {hi, lo} <= shifted;
          cnt      <= cnt + CNT_W'(1);
          if (cnt == LAST_STEP) begin
            product   <= shifted;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          // Unreachable encoding: recover to IDLE.
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SHIFT_ADD_MULT_DONE_CNT_EN
  // out_valid is only high in DONE, so this counts completed output handshakes.
  always_ff @(posedge clk) begin
    if (rst)
      done_count <= '0;
    else if (out_valid && out_ready)
      done_count <= done_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier (WIDTH=4).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// at the same point, i.e. reflecting the edge just taken.
module tb_shift_add_multiplier;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [2*W-1:0] product;
`ifdef SHIFT_ADD_MULT_DONE_CNT_EN
  logic [15:0]  done_count;
`endif

  int checks = 0;
  int errors = 0;

  shift_add_multiplier #(.WIDTH(W), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
`ifdef SHIFT_ADD_MULT_DONE_CNT_EN
    ,
    .done_count(done_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for out_valid; an expired bound shows up as a failed check.
  task automatic wait_valid(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid_seen"}, 16'(out_valid), 16'd1);
  endtask

  // One full transaction with cycle-exact latency checks. The accept edge
  // is followed by W edges in RUN; out_valid is visible after the W-th.
  task automatic do_mult(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [2*W-1:0] exp, input string tag);
    check({tag, "_ready_pre"}, 16'(in_ready), 16'd1);
    in_valid = 1'b1; a = x; b = y;
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, 16'(in_ready), 16'd0);
    for (int i = 0; i < W - 1; i++) begin
      tick();
      check({tag, "_early_valid"}, 16'(out_valid), 16'd0);
    end
    tick();
    check({tag, "_valid"}, 16'(out_valid), 16'd1);
    check({tag, "_product"}, 16'(product), 16'(exp));
    if (out_ready) begin
      tick();
      check({tag, "_valid_drop"}, 16'(out_valid), 16'd0);
      check({tag, "_ready_back"}, 16'(in_ready), 16'd1);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_in_ready", 16'(in_ready), 16'd1);
    check("reset_out_valid", 16'(out_valid), 16'd0);
    check("reset_product", 16'(product), 16'd0);

    // Basic vectors
    do_mult(4'd3, 4'd5, 8'h0F, "m3x5");
    do_mult(4'hF, 4'hF, 8'hE1, "mFxF");
    do_mult(4'h0, 4'hA, 8'h00, "m0xA");
    do_mult(4'h9, 4'h1, 8'h09, "m9x1");

    // Back-pressure: product held for 3 cycles, released by a single pulse
    out_ready = 1'b0;
    do_mult(4'd7, 4'd6, 8'h2A, "m7x6");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid_hold", 16'(out_valid), 16'd1);
      check("bp_product_hold", 16'(product), 16'h2A);
      check("bp_in_ready", 16'(in_ready), 16'd0);
    end
`ifdef SHIFT_ADD_MULT_DONE_CNT_EN
    check("cnt_no_inc_stall", done_count, 16'd4);
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", 16'(out_valid), 16'd0);
    check("bp_release_ready", 16'(in_ready), 16'd1);
    tick();
    out_ready = 1'b1;

    // in_valid held high with changing operands during RUN/DONE
    in_valid = 1'b1; a = 4'd2; b = 4'd7;
    tick();
    a = 4'hF; b = 4'hF;
    check("hold_busy", 16'(in_ready), 16'd0);
    for (int i = 0; i < W - 1; i++) begin
      tick();
      check("hold_early_valid", 16'(out_valid), 16'd0);
    end
    tick();
    check("hold_valid", 16'(out_valid), 16'd1);
    check("hold_product", 16'(product), 16'h0E);
    check("hold_busy_done", 16'(in_ready), 16'd0);
    tick();  // handshake edge -> IDLE
    check("hold_idle_ready", 16'(in_ready), 16'd1);
    tick();  // second operand pair accepted only now
    in_valid = 1'b0;
    check("hold_second_accept", 16'(in_ready), 16'd0);
    wait_valid("hold2");
    check("hold2_product", 16'(product), 16'hE1);
    tick();

    // Reset during the 2nd RUN cycle
    in_valid = 1'b1; a = 4'hC; b = 4'hB;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_out_valid", 16'(out_valid), 16'd0);
    check("rst_mid_product", 16'(product), 16'd0);
    check("rst_mid_in_ready", 16'(in_ready), 16'd1);
`ifdef SHIFT_ADD_MULT_DONE_CNT_EN
    check("cnt_after_rst", done_count, 16'd0);
`endif
    tick();
    check("rst_mid_quiet", 16'(out_valid), 16'd0);
    do_mult(4'd2, 4'd3, 8'h06, "m2x3");
`ifdef SHIFT_ADD_MULT_DONE_CNT_EN
    check("cnt_after_op", done_count, 16'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
